vc_fifo: RTL and testbench
==========================

# vc_fifo

Multi-virtual-channel input buffer for the NoC router ports, generalising the single 8×64 flit FIFO to NUM_VC independent queues of parametrised width and depth. Each VC has its own storage, pointers, occupancy count and status flags. A registered credit-return pulse on every successful pop feeds the upstream router's credit counters. It sits between the link receiver (write side) and the switch allocator/crossbar (read side).

## Interface
- DATA_W, 64, flit width in bits
- DEPTH, 8, entries per VC; power of two, ≥2
- NUM_VC, 2, number of virtual channels, ≥1
- AFULL_TH, DEPTH-2, per-VC count at or above which afull asserts; 1..DEPTH
- Derived: AW = $clog2(DEPTH); VW = max(1, $clog2(NUM_VC))

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- wr_en  in  1  push request
- wr_vc  in  VW  target VC of push
- din  in  DATA_W  flit to push
- rd_en  in  1  pop request
- rd_vc  in  VW  VC selected for pop and for dout
- dout  out  DATA_W  head flit of rd_vc (show-ahead)
- empty  out  NUM_VC  per-VC empty
- full  out  NUM_VC  per-VC full
- afull  out  NUM_VC  per-VC almost-full (count ≥ AFULL_TH)
- count  out  NUM_VC*(AW+1)  per-VC occupancy, VC v at bits [v*(AW+1) +: AW+1]
- cr_valid  out  1  credit-return pulse
- cr_vc  out  VW  VC the credit belongs to
- ovf  out  NUM_VC  sticky overflow flag (see Configuration)
- udf  out  NUM_VC  sticky underflow flag (see Configuration)

## Operation
- Per VC: wptr/rptr of AW+1 bits. empty = (wptr==rptr). full = MSBs differ and low AW bits equal. All DEPTH entries usable.
- Push accepted iff wr_en, wr_vc < NUM_VC, and !full[wr_vc] (pre-edge value). Flit written at wptr[AW-1:0]; wptr increments.
- Pop accepted iff rd_en, rd_vc < NUM_VC, and !empty[rd_vc] (pre-edge value). rptr increments; no data movement.
- Rejected push/pop: no state change. wr_vc/rd_vc ≥ NUM_VC: treated as rejected.
- dout = storage[rd_vc][rptr[AW-1:0]] combinationally. dout = 0 when empty[rd_vc] or rd_vc ≥ NUM_VC.
- count[v] = wptr−rptr (mod 2^(AW+1)). It is incremented/decremented by accepted ops. Simultaneous accepted push and pop on the same VC leaves count unchanged.
- Same-VC simultaneous push+pop:
  - VC empty: push accepted, pop rejected; no bypass.
  - VC full: pop accepted, push rejected.
  - Otherwise both accepted.
- Different VCs: push and pop are fully independent.
- Credit: cr_valid is a register set to 1 for exactly one cycle after each accepted pop, with cr_vc = that pop's rd_vc. Otherwise cr_valid = 0 and cr_vc holds its last value.
- Pointer wrap-around is natural modulo 2^(AW+1); no special handling.

## Timing
- Reset (rst=0 at edge) clears all pointers, count=0, empty=all 1, full=0, afull=0, cr_valid=0, cr_vc=0, ovf=udf=0. Storage is not cleared. dout=0 because all VCs are empty.
- A reset asserted mid-traffic discards all contents on that edge. Requests sampled on that edge are ignored.
- Push→dout visible: 1 cycle (the edge after an accepted push on an empty VC; dout valid immediately after, if rd_vc selects it).
- Pop→next head on dout: same edge.
- Pop→cr_valid: 1 cycle.
- empty/full/afull/count are functions of registered pointers only and are glitch-free relative to inputs. There is no combinational path from wr_*/rd_* to these flags.
- Full throughput: one push and one pop per cycle.

## Configuration
- Macro VC_FIFO_ERR_FLAG_EN.
  - Defined: ovf[v] sets on any cycle with wr_en=1, wr_vc=v and full[v]=1. udf[v] sets on rd_en=1, rd_vc=v and empty[v]=1. Both are sticky until reset.
  - Undefined: ovf and udf ports remain and are tied to 0. No flag registers are synthesised.

## Test plan
- Reset then push 0xA0..0xA7 to VC0 (DEPTH=8) → full[0]=1 after 8th edge, count0=8, afull[0]=1 from count=6, empty[1]=1 throughout.
- Pop VC0 8 times with rd_vc=0 → dout sequence 0xA0..0xA7, cr_valid pulses 8 cycles each 1 cycle late with cr_vc=0, final empty[0]=1, dout=0.
- Interleave: push VC1 0xB1 and pop VC0 in the same cycle → both accepted, count0−1, count1=1, cr_vc=0.
- Full VC0 with push+pop same cycle → pop accepted, push dropped, count0=7. Empty VC1 with push+pop → push accepted, count1=1, no cr_valid.
- Fill, drain, and refill VC0 20 times (pointer wrap) → data order preserved and full/empty are correct at every wrap.
- With VC_FIFO_ERR_FLAG_EN: push to full VC0 → ovf=01 sticky. Pop empty VC1 → udf=10. Reset (rst=0) → all flags 0. Without the macro → ovf=udf=0 always.

Source files
------------

// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC independent flit queues with show-ahead read and a registered credit-return pulse.
// Define VC_FIFO_ERR_FLAG_EN to build sticky per-VC overflow/underflow flags; otherwise ovf/udf read 0.
module vc_fifo #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int NUM_VC   = 2,
  parameter int AFULL_TH = DEPTH - 2,
  localparam int AW = $clog2(DEPTH),
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [VW-1:0]            wr_vc,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  input  logic [VW-1:0]            rd_vc,
  output logic [DATA_W-1:0]        dout,
  output logic [NUM_VC-1:0]        empty,
  output logic [NUM_VC-1:0]        full,
  output logic [NUM_VC-1:0]        afull,
  output logic [NUM_VC*(AW+1)-1:0] count,
  output logic                     cr_valid,
  output logic [VW-1:0]            cr_vc,
  output logic [NUM_VC-1:0]        ovf,
  output logic [NUM_VC-1:0]        udf
);

  localparam int NSEL = 1 << VW;

  logic [NUM_VC-1:0] push_ok;
  logic [NUM_VC-1:0] pop_ok;
  logic [NSEL-1:0]   sel_empty;
  logic [DATA_W-1:0] head [NSEL];

  // Select space is padded to 2**VW so out-of-range VC codes look permanently empty.
  for (genvar v = 0; v < NSEL; v++) begin : g_vc
    if (v < NUM_VC) begin : g_live
      logic [AW:0]       wptr;
      logic [AW:0]       rptr;
      logic [AW:0]       cnt;
      logic              wr_hit;
      logic              rd_hit;
      logic [DATA_W-1:0] mem [DEPTH];

      assign wr_hit = wr_en && (wr_vc == VW'(v));
      assign rd_hit = rd_en && (rd_vc == VW'(v));

      assign cnt      = wptr - rptr;
      assign empty[v] = (wptr == rptr);
      assign full[v]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      assign afull[v] = (cnt >= (AW+1)'(AFULL_TH));
      assign count[v*(AW+1) +: AW+1] = cnt;

      assign push_ok[v]   = wr_hit && !full[v];
      assign pop_ok[v]    = rd_hit && !empty[v];
      assign sel_empty[v] = empty[v];
      assign head[v]      = mem[rptr[AW-1:0]];

      always_ff @(posedge clk) begin
        if (!rst) begin
          wptr <= '0;
          rptr <= '0;
        end else begin
          if (push_ok[v]) wptr <= wptr + 1'b1;
          if (pop_ok[v])  rptr <= rptr + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst && push_ok[v]) mem[wptr[AW-1:0]] <= din;
      end

`ifdef VC_FIFO_ERR_FLAG_EN
      logic ovf_r;
      logic udf_r;

      always_ff @(posedge clk) begin
        if (!rst) begin
          ovf_r <= 1'b0;
          udf_r <= 1'b0;
        end else begin
          if (wr_hit && full[v])  ovf_r <= 1'b1;
          if (rd_hit && empty[v]) udf_r <= 1'b1;
        end
      end

      assign ovf[v] = ovf_r;
      assign udf[v] = udf_r;
`else
      assign ovf[v] = 1'b0;
      assign udf[v] = 1'b0;
`endif
    end else begin : g_pad
      assign sel_empty[v] = 1'b1;
      assign head[v]      = '0;
    end
  end

  always_comb begin
    dout = '0;
    if (!sel_empty[rd_vc]) dout = head[rd_vc];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cr_valid <= 1'b0;
      cr_vc    <= '0;
    end else begin
      cr_valid <= |pop_ok;
      if (|pop_ok) cr_vc <= rd_vc;
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// Scoreboard bench for vc_fifo (DEPTH=8, NUM_VC=2, DATA_W=64, AFULL_TH=6).
module tb_vc_fifo;

  typedef struct packed {
    logic [0:0]  vc;
    logic [63:0] d;
  } sb_t;

  typedef struct packed {
    logic [0:0]  vc;
    logic [31:0] at;
  } cr_t;

`ifdef VC_FIFO_ERR_FLAG_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_vc = '0;
  logic [63:0] din = '0;
  logic        rd_en = 1'b0;
  logic [0:0]  rd_vc = '0;
  logic [63:0] dout;
  logic [1:0]  empty, full, afull, ovf, udf;
  logic [7:0]  count;
  logic        cr_valid;
  logic [0:0]  cr_vc;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] cyc = '0;

  sb_t sb_q[$];
  cr_t cr_q[$];
  logic [63:0] mq0[$];
  logic [63:0] mq1[$];

  vc_fifo #(.DATA_W(64), .DEPTH(8), .NUM_VC(2), .AFULL_TH(6)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .din(din),
    .rd_en(rd_en), .rd_vc(rd_vc), .dout(dout), .empty(empty), .full(full),
    .afull(afull), .count(count), .cr_valid(cr_valid), .cr_vc(cr_vc),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every pop the DUT performs and every credit it emits.
  always @(negedge clk) begin
    sb_t e;
    cr_t c;
    if (rst) begin
      if (rd_en && !empty[rd_vc]) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pop", {63'd0, 1'b1}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("pop_vc", 64'(rd_vc), 64'(e.vc));
          chk("pop_dout", dout, e.d);
        end
      end
      if (cr_valid) begin
        if (cr_q.size() == 0) begin
          chk("unexpected_credit", {63'd0, cr_valid}, 64'd0);
        end else begin
          c = cr_q.pop_front();
          chk("cr_vc", 64'(cr_vc), 64'(c.vc));
          chk("cr_cycle", 64'(cyc), 64'(c.at));
        end
      end else if (cr_q.size() != 0 && cr_q[0].at <= cyc) begin
        c = cr_q.pop_front();
        chk("missing_credit", {63'd0, cr_valid}, 64'd1);
      end
    end
  end

  // One clock of stimulus; exp_push/exp_pop are the hand-derived acceptance outcomes.
  task automatic do_op(input bit we, input bit wvc, input logic [63:0] d, input bit exp_push,
                       input bit re, input bit rvc, input bit exp_pop);
    logic [63:0] h;
    wr_en = we; wr_vc = wvc; din = d; rd_en = re; rd_vc = rvc;
    if (exp_pop) begin
      h = rvc ? mq1.pop_front() : mq0.pop_front();
      sb_q.push_back('{vc: rvc, d: h});
      cr_q.push_back('{vc: rvc, at: cyc + 1});
    end
    if (exp_push) begin
      if (wvc) mq1.push_back(d);
      else     mq0.push_back(d);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset with requests active: they must be ignored.
    wr_en = 1'b1; din = 64'hDEAD; rd_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b1;
    chk("rst_empty", 64'(empty), 64'h3);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_afull", 64'(afull), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_cr", {62'd0, cr_valid, cr_vc}, 64'h0);
    chk("rst_err", {60'd0, ovf, udf}, 64'h0);
    chk("rst_dout", dout, 64'h0);

    // Fill VC0 with A0..A7.
    for (int i = 0; i < 8; i++) begin
      do_op(1, 0, 64'hA0 + 64'(i), 1, 0, 0, 0);
      chk("fill_count0", 64'(count[3:0]), 64'(i + 1));
      chk("fill_afull0", 64'(afull[0]), 64'(i + 1 >= 6));
      chk("fill_full0", 64'(full[0]), 64'(i == 7));
      chk("fill_empty", 64'(empty), 64'h2);
      if (i == 0) chk("showahead_dout", dout, 64'hA0);
    end
    do_op(1, 0, 64'hA8, 0, 0, 0, 0);
    chk("ovf_push_count0", 64'(count[3:0]), 64'd8);
    chk("ovf_flag", 64'(ovf), {62'd0, 1'b0, ERR});

    // Drain VC0: monitor checks A0..A7 order and one-cycle-late credits.
    for (int i = 0; i < 8; i++) begin
      do_op(0, 0, 64'h0, 0, 1, 0, 1);
      chk("drain_count0", 64'(count[3:0]), 64'(7 - i));
    end
    chk("drain_empty0", 64'(empty[0]), 64'd1);
    chk("drain_dout0", dout, 64'h0);

    // Interleave: push VC1 while popping VC0.
    do_op(1, 0, 64'hC0, 1, 0, 0, 0);
    do_op(1, 0, 64'hC1, 1, 0, 0, 0);
    do_op(1, 1, 64'hB1, 1, 1, 0, 1);
    chk("ilv_count0", 64'(count[3:0]), 64'd1);
    chk("ilv_count1", 64'(count[7:4]), 64'd1);
    do_op(0, 0, 64'h0, 0, 1, 1, 1);
    do_op(0, 0, 64'h0, 0, 1, 0, 1);
    chk("ilv_empty", 64'(empty), 64'h3);

    // Full VC0 with push+pop: pop wins, push dropped.
    for (int i = 0; i < 8; i++) do_op(1, 0, 64'hD0 + 64'(i), 1, 0, 0, 0);
    do_op(1, 0, 64'hD8, 0, 1, 0, 1);
    chk("fullpp_count0", 64'(count[3:0]), 64'd7);
    chk("fullpp_full0", 64'(full[0]), 64'd0);
    for (int i = 0; i < 7; i++) do_op(0, 0, 64'h0, 0, 1, 0, 1);
    chk("fullpp_empty0", 64'(empty[0]), 64'd1);

    // Empty VC1 with push+pop: push wins, no credit, no bypass.
    do_op(1, 1, 64'hE1, 1, 1, 1, 0);
    chk("emptypp_count1", 64'(count[7:4]), 64'd1);
    chk("udf_flag", 64'(udf), {62'd0, ERR, 1'b0});
    chk("ovf_sticky", 64'(ovf), {62'd0, 1'b0, ERR});
    do_op(0, 0, 64'h0, 0, 1, 1, 1);
    do_op(0, 0, 64'h0, 0, 0, 1, 0);
    chk("cr_hold", {62'd0, cr_valid, cr_vc}, 64'h1);

    // Pointer wrap: fill/drain VC0 twenty times.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 8; i++) do_op(1, 0, 64'h1000 + 64'(k * 16 + i), 1, 0, 0, 0);
      chk("wrap_full0", 64'({full[0], empty[0]}), 64'h2);
      for (int i = 0; i < 8; i++) do_op(0, 0, 64'h0, 0, 1, 0, 1);
      chk("wrap_empty0", 64'({full[0], empty[0]}), 64'h1);
    end

    // Full throughput: simultaneous push+pop keeps count steady.
    do_op(1, 0, 64'hF0, 1, 0, 0, 0);
    do_op(1, 0, 64'hF1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      do_op(1, 0, 64'h60 + 64'(i), 1, 1, 0, 1);
      chk("tput_count0", 64'(count[3:0]), 64'd2);
    end
    do_op(0, 0, 64'h0, 0, 1, 0, 1);
    do_op(0, 0, 64'h0, 0, 1, 0, 1);
    chk("tput_empty0", 64'(empty[0]), 64'd1);

    // Mid-traffic reset discards contents and ignores concurrent requests.
    do_op(1, 1, 64'h71, 1, 0, 1, 0);
    do_op(1, 1, 64'h72, 1, 0, 1, 0);
    rst = 1'b0; wr_en = 1'b1; wr_vc = 1'b0; din = 64'h99; rd_en = 1'b1; rd_vc = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    mq1.delete();
    chk("mrst_empty", 64'(empty), 64'h3);
    chk("mrst_count", 64'(count), 64'h0);
    chk("mrst_cr", {62'd0, cr_valid, cr_vc}, 64'h0);
    chk("mrst_err", {60'd0, ovf, udf}, 64'h0);
    chk("mrst_dout", dout, 64'h0);
    do_op(1, 1, 64'h81, 1, 0, 1, 0);
    chk("mrst_newhead", dout, 64'h81);
    do_op(0, 0, 64'h0, 0, 1, 1, 1);

    repeat (3) do_op(0, 0, 64'h0, 0, 0, 0, 0);
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    chk("cr_leftover", 64'(cr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
